// File: rtl/axi_pkg.sv
// Shared AXI4 types and helpers for the axi_dpmem burst sequencers.
package axi_pkg;

    localparam int AXI_4KB = 4096;

    typedef enum logic [2:0] {
        ONE_BYTE      = 3'd0,
        TWO_BYTES     = 3'd1,
        FOUR_BYTES    = 3'd2,
        EIGHT_BYTES   = 3'd3,
        SIXTEEN_BYTES = 3'd4,
        BYTES_32      = 3'd5,
        BYTES_64      = 3'd6,
        BYTES_128     = 3'd7
    } size_enum_t;

    typedef size_enum_t size_t;

    typedef enum logic [1:0] {
        FIXED    = 2'd0,
        INCR     = 2'd1,
        WRAP     = 2'd2,
        RESERVED = 2'd3
    } burst_enum_t;

    typedef logic [7:0] len_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [7:0]  idx;
        logic        last;
    } beat_t;

    function automatic logic [7:0] size_bytes(input size_t size);
        return 8'd1 << size;
    endfunction

    function automatic logic wrap_len_ok(input len_t len);
        case (len)
            8'd1, 8'd3, 8'd7, 8'd15: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/axi_beat_strb.sv
// Combinational lane-strobe decoder: active lanes from the address offset up to
// the next transfer-size boundary. Shared with the dpmem write-strobe merge.
module axi_beat_strb #(
    parameter int STRB_WIDTH = 4,
    parameter int OFF_W      = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 1
) (
    input  logic [OFF_W-1:0]      addr_lsb,
    input  logic [2:0]            size,
    output logic [STRB_WIDTH-1:0] strb
);

    logic [31:0] bytes_s;
    logic [31:0] lo_s;
    logic [31:0] hi_s;

    // Lanes in [offset, aligned offset + size) are enabled.
    always_comb begin
        strb    = '0;
        bytes_s = 32'd1 << size;
        lo_s    = 32'(addr_lsb);
        hi_s    = (lo_s & ~(bytes_s - 32'd1)) + bytes_s;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            strb[i] = (32'(i) >= lo_s) && (32'(i) < hi_s);
        end
    end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// AXI4 burst address/strobe sequencer (FIXED/INCR/WRAP, unaligned starts).
// Optional command legality checking is built when AXI_BURST_CHECK_EN is defined.
import axi_pkg::*;

module axi_burst_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [LEN_WIDTH-1:0]      cmd_len,
    input  logic [2:0]                cmd_size,
    input  logic [1:0]                cmd_burst,
    output logic                      beat_valid,
    input  logic                      beat_ready,
    output logic [ADDR_WIDTH-1:0]     beat_addr,
    output logic [DATA_WIDTH/8-1:0]   beat_strb,
    output logic [LEN_WIDTH-1:0]      beat_idx,
    output logic                      beat_last,
    output logic                      cmd_err
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFF_W      = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 1;

    typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t                  state_r, state_nxt_s;
    size_t                   size_r;
    burst_enum_t             burst_r;
    logic [LEN_WIDTH-1:0]    len_r;
    logic [ADDR_WIDTH-1:0]   wrap_mask_r;
    logic                    beat_valid_r, beat_last_r;
    logic [ADDR_WIDTH-1:0]   beat_addr_r;
    logic [STRB_WIDTH-1:0]   beat_strb_r;
    logic [LEN_WIDTH-1:0]    beat_idx_r;

    logic                    accept_s, hs_s, kill_s;
    logic [ADDR_WIDTH-1:0]   bytes_s, cur_aligned_s, incr_s, lower_s, next_addr_s;
    logic [ADDR_WIDTH-1:0]   cmd_mask_s, sel_addr_s;
    logic [2:0]              sel_size_s;
    logic [OFF_W-1:0]        sel_lsb_s;
    logic [STRB_WIDTH-1:0]   strb_dec_s;

    assign accept_s  = cmd_valid && cmd_ready;
    assign hs_s      = beat_valid_r && beat_ready;
    assign cmd_ready = (state_r == IDLE) || (hs_s && beat_last_r);

    assign beat_valid = beat_valid_r;
    assign beat_addr  = beat_addr_r;
    assign beat_strb  = beat_strb_r;
    assign beat_idx   = beat_idx_r;
    assign beat_last  = beat_last_r;

    // Address of the beat following the current one.
    always_comb begin
        bytes_s       = ADDR_WIDTH'(size_bytes(size_r));
        cur_aligned_s = beat_addr_r & ~(bytes_s - ADDR_WIDTH'(1));
        incr_s        = cur_aligned_s + bytes_s;
        lower_s       = beat_addr_r & ~wrap_mask_r;
        case (burst_r)
            FIXED:   next_addr_s = beat_addr_r;
            INCR:    next_addr_s = incr_s;
            WRAP: begin
                if (incr_s == lower_s + wrap_mask_r + ADDR_WIDTH'(1)) begin
                    next_addr_s = lower_s;
                end else begin
                    next_addr_s = incr_s;
                end
            end
            default: next_addr_s = incr_s;
        endcase
    end

    // Wrap window mask (total bytes - 1) for the incoming command.
    always_comb begin
        cmd_mask_s = ADDR_WIDTH'(size_bytes(size_t'(cmd_size)))
                   * (ADDR_WIDTH'(cmd_len) + ADDR_WIDTH'(1)) - ADDR_WIDTH'(1);
    end

    // One decoder serves both the first beat of a new command and later beats.
    always_comb begin
        if (accept_s) begin
            sel_addr_s = cmd_addr;
            sel_size_s = cmd_size;
        end else begin
            sel_addr_s = next_addr_s;
            sel_size_s = size_r;
        end
        sel_lsb_s = sel_addr_s[OFF_W-1:0] & OFF_W'(STRB_WIDTH - 1);
    end

    axi_beat_strb #(.STRB_WIDTH(STRB_WIDTH), .OFF_W(OFF_W)) u_strb (
        .addr_lsb (sel_lsb_s),
        .size     (sel_size_s),
        .strb     (strb_dec_s)
    );

`ifdef AXI_BURST_CHECK_EN
    logic        err_s, err_r;
    logic [31:0] chk_bytes_s, chk_total_s, page_off_s;

    // Illegal-command detection on the incoming command.
    always_comb begin
        chk_bytes_s = 32'(size_bytes(size_t'(cmd_size)));
        chk_total_s = chk_bytes_s * (32'(cmd_len) + 32'd1);
        page_off_s  = 32'(cmd_addr[11:0]) & ~(chk_bytes_s - 32'd1);
        err_s = (cmd_burst == RESERVED)
             || ((cmd_burst == WRAP) && !wrap_len_ok(len_t'(cmd_len)))
             || ((cmd_burst == WRAP) && ((cmd_addr & ADDR_WIDTH'(chk_bytes_s - 32'd1)) != '0))
             || (chk_bytes_s > 32'(STRB_WIDTH))
             || ((cmd_burst == INCR) && (page_off_s + chk_total_s > 32'(AXI_4KB)));
    end

    // Error flag captured with the command and held through the burst.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            err_r <= 1'b0;
        end else if (accept_s) begin
            err_r <= err_s;
        end
    end

    assign kill_s  = accept_s ? err_s : err_r;
    assign cmd_err = err_r;
`else
    assign kill_s  = 1'b0;
    assign cmd_err = 1'b0;
`endif

    // FSM next state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = BURST;
                else          state_nxt_s = IDLE;
            end
            BURST: begin
                if (hs_s && beat_last_r && !accept_s) state_nxt_s = IDLE;
                else                                  state_nxt_s = BURST;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state_r <= IDLE;
        else          state_r <= state_nxt_s;
    end

    // Command capture and beat sequencing; beats hold while stalled.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            size_r       <= ONE_BYTE;
            burst_r      <= FIXED;
            len_r        <= '0;
            wrap_mask_r  <= '0;
            beat_valid_r <= 1'b0;
            beat_addr_r  <= '0;
            beat_strb_r  <= '0;
            beat_idx_r   <= '0;
            beat_last_r  <= 1'b0;
        end else if (accept_s) begin
            size_r       <= size_t'(cmd_size);
            burst_r      <= burst_enum_t'(cmd_burst);
            len_r        <= cmd_len;
            wrap_mask_r  <= cmd_mask_s;
            beat_valid_r <= 1'b1;
            beat_addr_r  <= cmd_addr;
            beat_strb_r  <= kill_s ? '0 : strb_dec_s;
            beat_idx_r   <= '0;
            beat_last_r  <= (cmd_len == '0);
        end else if (hs_s) begin
            if (beat_last_r) begin
                beat_valid_r <= 1'b0;
            end else begin
                beat_addr_r <= next_addr_s;
                beat_strb_r <= kill_s ? '0 : strb_dec_s;
                beat_idx_r  <= beat_idx_r + LEN_WIDTH'(1);
                beat_last_r <= ((beat_idx_r + LEN_WIDTH'(1)) == len_r);
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Directed self-checking bench for axi_burst_addr_gen (32-bit address/data, 8-bit len).
import axi_pkg::*;

module tb_axi_burst_addr_gen;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic        beat_valid;
    logic        beat_ready;
    logic [31:0] beat_addr;
    logic [3:0]  beat_strb;
    logic [7:0]  beat_idx;
    logic        beat_last;
    logic        cmd_err;

    int n_vec = 0;
    int n_err = 0;

    logic [46:0] got;
    logic [46:0] exp;
    assign got = {beat_valid, beat_addr, beat_strb, beat_idx, beat_last, cmd_err};

    always #5 ACLK = ~ACLK;

    axi_burst_addr_gen #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_size   (cmd_size),
        .cmd_burst  (cmd_burst),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_addr  (beat_addr),
        .beat_strb  (beat_strb),
        .beat_idx   (beat_idx),
        .beat_last  (beat_last),
        .cmd_err    (cmd_err)
    );

    task automatic issue_cmd(input logic [31:0] a, input logic [7:0] l,
                             input logic [2:0] s, input logic [1:0] b);
        @(negedge ACLK);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_size  = s;
        cmd_burst = b;
        cmd_valid = 1'b1;
        @(posedge ACLK);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if ({cmd_ready, got} !== {1'b1, 47'd0}) begin
            n_err++;
            $display("FAIL reset_during got=%h exp=%h", {cmd_ready, got}, {1'b1, 47'd0});
        end
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        n_vec++;
        if ({cmd_ready, got} !== {1'b1, 47'd0}) begin
            n_err++;
            $display("FAIL reset_after got=%h exp=%h", {cmd_ready, got}, {1'b1, 47'd0});
        end
        beat_ready = 1'b1;
    endtask

    task automatic test_incr();
        logic [31:0] ea [4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        issue_cmd(32'h1000, 8'd3, FOUR_BYTES, INCR);
        for (int k = 0; k < 4; k++) begin
            @(negedge ACLK);
            exp = {1'b1, ea[k], 4'hF, 8'(k), (k == 3), 1'b0};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL incr_beat%0d got=%h exp=%h", k, got, exp);
            end
        end
        @(negedge ACLK);
        n_vec++;
        if ({beat_valid, cmd_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL incr_idle got=%b exp=01", {beat_valid, cmd_ready});
        end
    endtask

    task automatic test_unaligned();
        logic [31:0] ea [2] = '{32'h1002, 32'h1004};
        logic [3:0]  es [2] = '{4'hC, 4'hF};
        issue_cmd(32'h1002, 8'd1, FOUR_BYTES, INCR);
        for (int k = 0; k < 2; k++) begin
            @(negedge ACLK);
            exp = {1'b1, ea[k], es[k], 8'(k), (k == 1), 1'b0};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL unaligned_beat%0d got=%h exp=%h", k, got, exp);
            end
        end
        @(negedge ACLK);
        n_vec++;
        if ({beat_valid, cmd_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL unaligned_idle got=%b exp=01", {beat_valid, cmd_ready});
        end
    endtask

    task automatic test_wrap();
        logic [31:0] ea [4] = '{32'h38, 32'h3C, 32'h30, 32'h34};
        issue_cmd(32'h38, 8'd3, FOUR_BYTES, WRAP);
        for (int k = 0; k < 4; k++) begin
            @(negedge ACLK);
            exp = {1'b1, ea[k], 4'hF, 8'(k), (k == 3), 1'b0};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL wrap_beat%0d got=%h exp=%h", k, got, exp);
            end
        end
        @(negedge ACLK);
        n_vec++;
        if ({beat_valid, cmd_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL wrap_idle got=%b exp=01", {beat_valid, cmd_ready});
        end
    endtask

    task automatic test_fixed();
        issue_cmd(32'h20, 8'd2, ONE_BYTE, FIXED);
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            exp = {1'b1, 32'h20, 4'h1, 8'(k), (k == 2), 1'b0};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL fixed_beat%0d got=%h exp=%h", k, got, exp);
            end
        end
        @(negedge ACLK);
        n_vec++;
        if ({beat_valid, cmd_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL fixed_idle got=%b exp=01", {beat_valid, cmd_ready});
        end
    endtask

    task automatic test_back_to_back();
        issue_cmd(32'h200, 8'd2, FOUR_BYTES, INCR);
        @(negedge ACLK);
        exp = {1'b1, 32'h200, 4'hF, 8'd0, 1'b0, 1'b0};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL b2b_beat0 got=%h exp=%h", got, exp);
        end
        @(negedge ACLK);
        beat_ready = 1'b0;
        exp = {1'b1, 32'h204, 4'hF, 8'd1, 1'b0, 1'b0};
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge ACLK);
            #1;
            n_vec++;
            if (got !== exp || cmd_ready !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_stall%0d got=%h/%b exp=%h/0", c, got, cmd_ready, exp);
            end
        end
        beat_ready = 1'b1;
        @(negedge ACLK);
        exp = {1'b1, 32'h208, 4'hF, 8'd2, 1'b1, 1'b0};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL b2b_beat2 got=%h exp=%h", got, exp);
        end
        cmd_addr  = 32'h300;
        cmd_len   = 8'd0;
        cmd_size  = FOUR_BYTES;
        cmd_burst = INCR;
        cmd_valid = 1'b1;
        #1;
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready got=%b exp=1", cmd_ready);
        end
        @(posedge ACLK);
        #1 cmd_valid = 1'b0;
        @(negedge ACLK);
        exp = {1'b1, 32'h300, 4'hF, 8'd0, 1'b1, 1'b0};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL b2b_second got=%h exp=%h", got, exp);
        end
        @(negedge ACLK);
        n_vec++;
        if ({beat_valid, cmd_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL b2b_idle got=%b exp=01", {beat_valid, cmd_ready});
        end
    endtask

    task automatic test_reset_mid();
        issue_cmd(32'h400, 8'd3, FOUR_BYTES, INCR);
        @(negedge ACLK);
        @(negedge ACLK);
        @(negedge ACLK);
        exp = {1'b1, 32'h408, 4'hF, 8'd2, 1'b0, 1'b0};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL rstmid_beat2 got=%h exp=%h", got, exp);
        end
        ARESETn = 1'b0;
        #1;
        n_vec++;
        if ({cmd_ready, got} !== {1'b1, 47'd0}) begin
            n_err++;
            $display("FAIL rstmid_drop got=%h exp=%h", {cmd_ready, got}, {1'b1, 47'd0});
        end
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        n_vec++;
        if ({cmd_ready, got} !== {1'b1, 47'd0}) begin
            n_err++;
            $display("FAIL rstmid_idle got=%h exp=%h", {cmd_ready, got}, {1'b1, 47'd0});
        end
    endtask

`ifdef AXI_BURST_CHECK_EN
    task automatic test_check();
        issue_cmd(32'h40, 8'd2, FOUR_BYTES, WRAP);
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            n_vec++;
            if ({beat_valid, beat_strb, beat_idx, beat_last, cmd_err} !==
                {1'b1, 4'h0, 8'(k), (k == 2), 1'b1}) begin
                n_err++;
                $display("FAIL check_beat%0d got=%h exp=%h", k,
                         {beat_valid, beat_strb, beat_idx, beat_last, cmd_err},
                         {1'b1, 4'h0, 8'(k), (k == 2), 1'b1});
            end
        end
        @(negedge ACLK);
        n_vec++;
        if ({beat_valid, cmd_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL check_idle got=%b exp=01", {beat_valid, cmd_ready});
        end
    endtask
`endif

    initial begin
        ARESETn    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_addr   = 32'h0;
        cmd_len    = 8'd0;
        cmd_size   = 3'd0;
        cmd_burst  = 2'd0;
        beat_ready = 1'b0;
        test_reset();
        test_incr();
        test_unaligned();
        test_wrap();
        test_fixed();
        test_back_to_back();
        test_reset_mid();
`ifdef AXI_BURST_CHECK_EN
        test_check();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
